// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes (RV funct3)
// and small decode helpers.
package muldiv_pkg;

    localparam int unsigned MD_OP_WIDTH = 3;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // MUL low half is sign-agnostic, so it is computed as unsigned.
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MdMulh) || (op == MdMulhsu) || (op == MdDiv) || (op == MdRem);
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op == MdMulh) || (op == MdDiv) || (op == MdRem);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply (acc:lo shifts right)
// or restoring divide (acc:lo shifts left, quotient bits enter at lo[0]).
module muldiv_step #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              is_div,
    input  logic [DWIDTH-1:0] acc,
    input  logic [DWIDTH-1:0] lo,
    input  logic [DWIDTH-1:0] operand,
    input  logic [CNT_W-1:0]  cnt,
    output logic [DWIDTH-1:0] acc_next,
    output logic [DWIDTH-1:0] lo_next,
    output logic [CNT_W-1:0]  cnt_next
);

    logic [DWIDTH:0]   sum;
    logic [DWIDTH:0]   shifted;
    logic [DWIDTH-1:0] diff;
    logic              fits;

    always_comb begin
        sum      = {1'b0, acc} + (lo[0] ? {1'b0, operand} : '0);
        shifted  = {acc, lo[DWIDTH-1]};
        fits     = shifted >= {1'b0, operand};
        // Partial remainder is always below the divisor, so the low bits suffice.
        diff     = shifted[DWIDTH-1:0] - operand;
        cnt_next = cnt + CNT_W'(1);
        if (is_div) begin
            acc_next = fits ? diff : shifted[DWIDTH-1:0];
            lo_next  = {lo[DWIDTH-2:0], fits};
        end else begin
            acc_next = sum[DWIDTH:1];
            lo_next  = {sum[0], lo[DWIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fixup in a final cycle, result held until accepted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic [DWIDTH-1:0]      a,
    input  logic [DWIDTH-1:0]      b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      y
);

    localparam int unsigned CNT_W = $clog2(DWIDTH) + 1;
    localparam logic [DWIDTH-1:0] MinVal = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_op_e            op_q, op_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] lo_q, lo_d;
    logic [DWIDTH-1:0] opnd_q, opnd_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DWIDTH-1:0] y_q, y_d;

    logic [DWIDTH-1:0] acc_step, lo_step;
    logic [CNT_W-1:0]  cnt_step;

    md_op_e              op_in;
    logic                a_sgn, b_sgn, in_div, div_zero, div_ovf;
    logic [DWIDTH-1:0]   a_mag, b_mag;
    logic [2*DWIDTH-1:0] prod, prod_fix;
    logic [DWIDTH-1:0]   quot_fix, rem_fix;

    muldiv_step #(
        .DWIDTH (DWIDTH),
        .CNT_W  (CNT_W)
    ) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc_q),
        .lo       (lo_q),
        .operand  (opnd_q),
        .cnt      (cnt_q),
        .acc_next (acc_step),
        .lo_next  (lo_step),
        .cnt_next (cnt_step)
    );

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;

    // Operand decode at the accept edge.
    always_comb begin
        op_in    = md_op_e'(op);
        in_div   = op_is_div(op_in);
        a_sgn    = op_a_signed(op_in) & a[DWIDTH-1];
        b_sgn    = op_b_signed(op_in) & b[DWIDTH-1];
        a_mag    = a_sgn ? -a : a;
        b_mag    = b_sgn ? -b : b;
        div_zero = in_div && (b == '0);
        div_ovf  = ((op_in == MdDiv) || (op_in == MdRem)) && (a == MinVal) && (b == '1);
    end

    // Sign fixup of the finished magnitudes.
    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_res_q ? -prod : prod;
        quot_fix = neg_res_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        y_d       = y_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d      = op_in;
                        neg_res_d = a_sgn ^ b_sgn;
                        neg_rem_d = a_sgn;
                        cnt_d     = '0;
                        acc_d     = '0;
                        lo_d      = in_div ? a_mag : b_mag;
                        opnd_d    = in_div ? b_mag : a_mag;
                        if (div_zero) begin
                            y_d     = op_in[1] ? a : '1;
                            state_d = StDone;
                        end else if (div_ovf) begin
                            y_d     = op_in[1] ? '0 : a;
                            state_d = StDone;
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_d = acc_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_step;
                    if (cnt_q == CNT_W'(DWIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    unique case (op_q)
                        MdMul:                    y_d = prod_fix[DWIDTH-1:0];
                        MdMulh, MdMulhsu, MdMulhu: y_d = prod_fix[2*DWIDTH-1:DWIDTH];
                        MdDiv, MdDivu:            y_d = quot_fix;
                        MdRem, MdRemu:            y_d = rem_fix;
                        default:                  y_d = y_q;
                    endcase
                    state_d = StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= MdMul;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            y_q       <= y_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, randomized ops against a
// 64-bit arithmetic model, backpressure, flush and asynchronous reset sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int passed;
    int total;

    muldiv_unit #(
        .DWIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: RV32M semantics via plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] z);
        longint      sx, sz, ux, uz;
        logic [63:0] p;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ux = longint'({32'b0, x});
        uz = longint'({32'b0, z});
        case (o)
            3'd0: begin p = ux * uz; return p[31:0]; end
            3'd1: begin p = sx * sz; return p[63:32]; end
            3'd2: begin p = sx * uz; return p[63:32]; end
            3'd3: begin p = ux * uz; return p[63:32]; end
            3'd4: begin
                if (z == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return x;
                p = sx / sz; return p[31:0];
            end
            3'd5: begin
                if (z == 32'd0) return 32'hFFFF_FFFF;
                p = ux / uz; return p[31:0];
            end
            3'd6: begin
                if (z == 32'd0) return x;
                if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sz; return p[31:0];
            end
            default: begin
                if (z == 32'd0) return x;
                p = ux % uz; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] z);
        if (o[2] && z == 32'd0) return 0;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after an edge while the unit is idle; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = z;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_done(output int lat, output bit busy_seen);
        lat = 0;
        busy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] z, input logic [31:0] exp_y, input int exp_lat);
        int lat;
        bit busy;
        issue(o, x, z);
        wait_done(lat, busy);
        chk({name, " y"}, y, exp_y);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " in_ready low while busy"}, {31'b0, busy}, 32'd0);
        accept_result();
        chk({name, " idle after accept"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int          lat;
        bit          busy;
        int          seen;
        logic [31:0] held_y;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 32'd0;
        b         = 32'd0;

        vecs.push_back('{3'd0, 32'd7,          32'd6,          32'd42,         33});
        vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33});
        vecs.push_back('{3'd3, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  0});
        vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,          0});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0});

        #12;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset y", y, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y,
                   vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb,
                   model(ro, ra, rb), model_lat(ro, ra, rb));
        end

        // Backpressure: result must hold while out_ready is low.
        issue(3'd0, 32'd123, 32'd456);
        wait_done(lat, busy);
        chk("bp y", y, 32'd56088);
        held_y = y;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || y !== held_y) seen++;
        end
        chk("bp stable", 32'(seen), 32'd0);
        accept_result();
        chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        run_op("bp second", 3'd5, 32'd1000, 32'd33, 32'd30, 33);

        // Flush during CALC.
        held_y = y;
        issue(3'd0, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush idle", {30'b0, out_valid, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush no out_valid", 32'(seen), 32'd0);
        chk("flush keeps y", y, held_y);

        // Flush coinciding with an accept of a special-case op: op is dropped.
        flush = 1'b1;
        issue(3'd5, 32'd5, 32'd0);
        flush = 1'b0;
        chk("flush accept idle", {30'b0, out_valid, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("flush accept no out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush accept keeps y", y, held_y);

        // Asynchronous reset mid-CALC, sampled before any further clock edge.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("async reset y", y, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after reset", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
